// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM states, requester IDs, default widths.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
// Contents: state_t, req_id_t, MEM_*_W defaults, onehot_to_id() helper.
package mem_pkg;

    localparam int MEM_ADDR_W = 30;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = MEM_DATA_W / 8;
    localparam int NUM_REQ    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Also used as the bit index into the one-hot grant vector.
    typedef enum logic [1:0] {
        REQ_WB = 2'd0,
        REQ_D  = 2'd1,
        REQ_I  = 2'd2
    } req_id_t;

    function automatic req_id_t onehot_to_id(input logic [NUM_REQ-1:0] gnt);
        req_id_t id;
        id = REQ_WB;
        if (gnt[REQ_D]) id = REQ_D;
        if (gnt[REQ_I]) id = REQ_I;
        return id;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the memory-port arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold en/adr/data until their done pulse; memory stalls via memdone.
// Modports: slave = arbiter view, master = requesters + memory (environment) view.
interface mem_port_arbiter_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int BE_W   = MEM_BE_W
);
    // write buffer
    logic              wben;
    logic [ADDR_W-1:0] wbadr;
    logic [DATA_W-1:0] wbdata;
    logic [BE_W-1:0]   wbbyteen;
    logic              wbdone;
    // data cache
    logic              den;
    logic [ADDR_W-1:0] dadr;
    logic              ddone;
    // instruction cache
    logic              ien;
    logic [ADDR_W-1:0] iadr;
    logic              idone;
    logic [DATA_W-1:0] rdata;
    // memory
    logic [ADDR_W-1:0] memadr;
    logic [DATA_W-1:0] memwdata;
    logic [BE_W-1:0]   membyteen;
    logic              memrwb;
    logic              memen;
    logic [DATA_W-1:0] memrdata;
    logic              memdone;

    modport slave (
        input  wben, wbadr, wbdata, wbbyteen, den, dadr, ien, iadr, memrdata, memdone,
        output wbdone, ddone, idone, rdata, memadr, memwdata, membyteen, memrwb, memen
    );

    modport master (
        output wben, wbadr, wbdata, wbbyteen, den, dadr, ien, iadr, memrdata, memdone,
        input  wbdone, ddone, idone, rdata, memadr, memwdata, membyteen, memrwb, memen
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Winner selection among WB / D / I requests; one-hot grant out, WB always first.
// Latency: grant is combinational from the request lines (pointer flop only in round-robin build).
// Backpressure: none; the caller consumes the grant only while its FSM is idle (i_take).
// Ports: clk, reset, i_wben/i_den/i_ien requests, i_take (grant accepted), o_grant one-hot.
// Macro ARB_ROUND_ROBIN_EN: D/I ties alternate; otherwise fixed WB > D > I.
module mem_arb_pick
    import mem_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_wben,
    input  logic               i_den,
    input  logic               i_ien,
    input  logic               i_take,
    output logic [NUM_REQ-1:0] o_grant
);

    logic w_i_first;   // on a D/I tie, give the port to I

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers the last D/I winner; REQ_WB means "no D/I grant yet", so D wins the first tie.
    req_id_t r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= REQ_WB;
        end else if (i_take && !o_grant[REQ_WB]) begin
            r_last <= o_grant[REQ_I] ? REQ_I : REQ_D;
        end
    end

    assign w_i_first = (r_last == REQ_D);
`else
    logic w_unused;
    assign w_unused  = &{1'b0, clk, reset, i_take};
    assign w_i_first = 1'b0;
`endif

    always_comb begin
        o_grant = '0;
        if (i_wben) begin
            o_grant[REQ_WB] = 1'b1;
        end else if (i_den && i_ien) begin
            if (w_i_first) o_grant[REQ_I] = 1'b1;
            else           o_grant[REQ_D] = 1'b1;
        end else if (i_den) begin
            o_grant[REQ_D] = 1'b1;
        end else if (i_ien) begin
            o_grant[REQ_I] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between write buffer (write-only), D-cache and I-cache (read-only).
// Latency: request sampled at edge 0 -> memen after edge 0 -> done pulse after edge 3 at the earliest.
// Backpressure: one transaction in flight; others wait with en held; memdone low stalls indefinitely.
// Ports: clk, reset (async, active-high), bus (mem_port_arbiter_if.slave: requester + memory signals).
// Macro ARB_ROUND_ROBIN_EN: alternate D/I on ties (see mem_arb_pick).
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int BE_W   = MEM_BE_W
)(
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    state_t              r_state;
    req_id_t             r_gnt;
    logic [ADDR_W-1:0]   r_memadr;
    logic [DATA_W-1:0]   r_memwdata;
    logic [BE_W-1:0]     r_membyteen;
    logic                r_memrwb;
    logic                r_memen;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_wbdone;
    logic                r_ddone;
    logic                r_idone;

    logic [NUM_REQ-1:0]  w_grant;
    logic                w_take;

    mem_arb_pick u_pick (
        .clk     (clk),
        .reset   (reset),
        .i_wben  (bus.wben),
        .i_den   (bus.den),
        .i_ien   (bus.ien),
        .i_take  (w_take),
        .o_grant (w_grant)
    );

    assign w_take = (r_state == IDLE) && (|w_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_gnt       <= REQ_WB;
            r_memadr    <= '0;
            r_memwdata  <= '0;
            r_membyteen <= '0;
            r_memrwb    <= 1'b1;
            r_memen     <= 1'b0;
            r_rdata     <= '0;
            r_wbdone    <= 1'b0;
            r_ddone     <= 1'b0;
            r_idone     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Latch the winner; mem* are driven from these copies until the
                    // transaction ends, so the requester's inputs no longer matter.
                    if (w_take) begin
                        r_gnt <= onehot_to_id(w_grant);
                        if (w_grant[REQ_WB]) begin
                            r_memadr    <= bus.wbadr;
                            r_memwdata  <= bus.wbdata;
                            r_membyteen <= bus.wbbyteen;
                            r_memrwb    <= 1'b0;
                        end else if (w_grant[REQ_D]) begin
                            r_memadr    <= bus.dadr;
                            r_memwdata  <= '0;
                            r_membyteen <= '0;
                            r_memrwb    <= 1'b1;
                        end else begin
                            r_memadr    <= bus.iadr;
                            r_memwdata  <= '0;
                            r_membyteen <= '0;
                            r_memrwb    <= 1'b1;
                        end
                        r_memen <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    // memdone is still high from the idle memory here; it only
                    // drops on this edge, so it cannot be trusted until WAIT.
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (bus.memdone) begin
                        r_memen  <= 1'b0;
                        if (r_memrwb) r_rdata <= bus.memrdata;
                        r_wbdone <= (r_gnt == REQ_WB);
                        r_ddone  <= (r_gnt == REQ_D);
                        r_idone  <= (r_gnt == REQ_I);
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    // One idle cycle follows so the requester can drop en before the next arbitration.
                    r_wbdone <= 1'b0;
                    r_ddone  <= 1'b0;
                    r_idone  <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.memadr    = r_memadr;
    assign bus.memwdata  = r_memwdata;
    assign bus.membyteen = r_membyteen;
    assign bus.memrwb    = r_memrwb;
    assign bus.memen     = r_memen;
    assign bus.rdata     = r_rdata;
    assign bus.wbdone    = r_wbdone;
    assign bus.ddone     = r_ddone;
    assign bus.idone     = r_idone;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int          id;
        logic [29:0] adr;
        logic        rwb;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_mem_q[$];
    exp_t exp_done_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int id, input logic [29:0] adr, input logic rwb,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input logic [31:0] rdata, input bit with_done);
        exp_t e;
        e.id = id; e.adr = adr; e.rwb = rwb; e.wdata = wdata; e.be = be; e.rdata = rdata;
        exp_mem_q.push_back(e);
        if (with_done) exp_done_q.push_back(e);
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem [logic [29:0]];
    int          m_st;
    int          m_cnt;
    int          stall_extra;
    logic [31:0] m_tmp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.memdone  <= 1'b1;
            bus.memrdata <= '0;
            m_st         <= 0;
            m_cnt        <= 0;
        end else begin
            case (m_st)
                0: if (bus.memen) begin
                    bus.memdone <= 1'b0;
                    m_cnt       <= stall_extra;
                    m_st        <= 1;
                end
                1: if (m_cnt > 0) begin
                    m_cnt <= m_cnt - 1;
                end else begin
                    if (bus.memrwb) begin
                        bus.memrdata <= mem[bus.memadr];
                    end else begin
                        m_tmp = mem[bus.memadr];
                        for (int b = 0; b < 4; b++)
                            if (bus.membyteen[b]) m_tmp[8*b +: 8] = bus.memwdata[8*b +: 8];
                        mem[bus.memadr] = m_tmp;
                    end
                    bus.memdone <= 1'b1;
                    m_st        <= 2;
                end
                default: if (!bus.memen) m_st <= 0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    logic prev_memen = 1'b0;
    logic prev_done  = 1'b0;
    exp_t mon_e;
    logic [2:0] mon_dones;

    always @(negedge clk) begin
        mon_dones = {bus.idone, bus.ddone, bus.wbdone};
        if (!reset) begin
            if (bus.memen && !prev_memen) begin
                chk("memen_window_expected", exp_mem_q.size() != 0, 1'b1);
                if (exp_mem_q.size() != 0) begin
                    mon_e = exp_mem_q.pop_front();
                    chk("memadr", bus.memadr, mon_e.adr);
                    chk("memrwb", bus.memrwb, mon_e.rwb);
                    if (!mon_e.rwb) begin
                        chk("memwdata", bus.memwdata, mon_e.wdata);
                        chk("membyteen", bus.membyteen, mon_e.be);
                    end
                end
            end
            if (mon_dones != 3'b000) begin
                chk("done_single_cycle", prev_done, 1'b0);
                chk("done_expected", exp_done_q.size() != 0, 1'b1);
                if (exp_done_q.size() != 0) begin
                    mon_e = exp_done_q.pop_front();
                    chk("done_who", mon_dones, 3'b001 << mon_e.id);
                    if (mon_e.rwb) chk("rdata", bus.rdata, mon_e.rdata);
                end
            end
        end
        prev_memen = bus.memen;
        prev_done  = (mon_dones != 3'b000);
    end

    // ---------------- stimulus helpers ----------------
    // Waits for n done pulses; drop[k] releases requester k's en on its done.
    task automatic run_until(input int n, input int budget, input logic [2:0] drop);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (bus.wbdone || bus.ddone || bus.idone) begin
                seen++;
                if (bus.wbdone && drop[0]) bus.wben = 1'b0;
                if (bus.ddone  && drop[1]) bus.den  = 1'b0;
                if (bus.idone  && drop[2]) bus.ien  = 1'b0;
            end
        end
        chk("dones_within_budget", seen, n);
    endtask

    task automatic wait_memen(input int budget);
        int cyc = 0;
        while (!bus.memen && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("memen_within_budget", bus.memen, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    int bad;

    initial begin
        mem[30'h000] = 32'hDEADBEEF;
        mem[30'h4AD] = 32'hAABBCCDD;
        mem[30'h100] = 32'h00000000;
        mem[30'h010] = 32'h11111111;
        mem[30'h020] = 32'h22222222;
        mem[30'h011] = 32'h33333333;
        mem[30'h021] = 32'h44444444;

        bus.wben = 0; bus.wbadr = '0; bus.wbdata = '0; bus.wbbyteen = '0;
        bus.den  = 0; bus.dadr  = '0;
        bus.ien  = 0; bus.iadr  = '0;
        stall_extra = 0;
        reset = 1'b0;
        #1 reset = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_memen",     bus.memen,     1'b0);
        chk("rst_memrwb",    bus.memrwb,    1'b1);
        chk("rst_memadr",    bus.memadr,    '0);
        chk("rst_memwdata",  bus.memwdata,  '0);
        chk("rst_membyteen", bus.membyteen, '0);
        chk("rst_rdata",     bus.rdata,     '0);
        chk("rst_dones",     {bus.wbdone, bus.ddone, bus.idone}, 3'b000);
        reset = 1'b0;

        // 1: single D read
        @(negedge clk);
        push_exp(REQ_D, 30'h0, 1'b1, '0, '0, 32'hDEADBEEF, 1);
        bus.den = 1; bus.dadr = 30'h0;
        run_until(1, 20, 3'b010);

        // 2: masked WB write
        @(negedge clk);
        push_exp(REQ_WB, 30'h4AD, 1'b0, 32'h21212121, 4'b1101, '0, 1);
        bus.wben = 1; bus.wbadr = 30'h4AD; bus.wbdata = 32'h21212121; bus.wbbyteen = 4'b1101;
        run_until(1, 20, 3'b001);
        chk("wb_byte_merge", mem[30'h4AD], 32'h2121CC21);

        // 3: simultaneous requests from a fresh pointer
        do_reset();
        push_exp(REQ_WB, 30'h100, 1'b0, 32'hCAFEF00D, 4'b1111, '0, 1);
        push_exp(REQ_D,  30'h010, 1'b1, '0, '0, 32'h11111111, 1);
        push_exp(REQ_I,  30'h020, 1'b1, '0, '0, 32'h22222222, 1);
        bus.wben = 1; bus.wbadr = 30'h100; bus.wbdata = 32'hCAFEF00D; bus.wbbyteen = 4'b1111;
        bus.den  = 1; bus.dadr  = 30'h010;
        bus.ien  = 1; bus.iadr  = 30'h020;
        run_until(3, 40, 3'b111);
        chk("wb_full_write", mem[30'h100], 32'hCAFEF00D);

        // 4: D and I held continuously
        @(negedge clk);
        bus.den = 1; bus.dadr = 30'h011;
        bus.ien = 1; bus.iadr = 30'h021;
`ifdef ARB_ROUND_ROBIN_EN
        push_exp(REQ_D, 30'h011, 1'b1, '0, '0, 32'h33333333, 1);
        push_exp(REQ_I, 30'h021, 1'b1, '0, '0, 32'h44444444, 1);
        push_exp(REQ_D, 30'h011, 1'b1, '0, '0, 32'h33333333, 1);
        push_exp(REQ_I, 30'h021, 1'b1, '0, '0, 32'h44444444, 1);
        run_until(3, 80, 3'b000);
        run_until(1, 30, 3'b110);
`else
        for (int k = 0; k < 4; k++)
            push_exp(REQ_D, 30'h011, 1'b1, '0, '0, 32'h33333333, 1);
        push_exp(REQ_I, 30'h021, 1'b1, '0, '0, 32'h44444444, 1);
        run_until(3, 80, 3'b000);
        run_until(1, 30, 3'b010);
        run_until(1, 30, 3'b100);
`endif

        // 5: reset in WAIT of a D read, then re-issue
        @(negedge clk);
        push_exp(REQ_D, 30'h0, 1'b1, '0, '0, 32'hDEADBEEF, 0);
        bus.den = 1; bus.dadr = 30'h0;
        wait_memen(10);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midreset_memen", bus.memen, 1'b0);
        chk("midreset_ddone", bus.ddone, 1'b0);
        chk("midreset_rdata", bus.rdata, '0);
        bus.den = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        push_exp(REQ_D, 30'h010, 1'b1, '0, '0, 32'h11111111, 1);
        bus.den = 1; bus.dadr = 30'h010;
        run_until(1, 20, 3'b010);

        // 6: memory stalls ~50 cycles in WAIT
        @(negedge clk);
        stall_extra = 50;
        push_exp(REQ_I, 30'h020, 1'b1, '0, '0, 32'h22222222, 1);
        bus.ien = 1; bus.iadr = 30'h020;
        wait_memen(10);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.memen !== 1'b1 || bus.memadr !== 30'h020 ||
                (bus.wbdone | bus.ddone | bus.idone) !== 1'b0) bad++;
        end
        chk("stall_stable", bad, 0);
        run_until(1, 100, 3'b100);
        stall_extra = 0;

        repeat (3) @(negedge clk);
        chk("mem_q_drained",  exp_mem_q.size(),  0);
        chk("done_q_drained", exp_done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
